// File: rtl/hs_order_split_merge.sv
// Order-preserving 4-phase split/merge controller: routes tokens to NCH branches
// and returns their completions downstream in issue order via a route FIFO.
module hs_order_split_merge #(
  parameter int NCH   = 3,
  parameter int DEPTH = 4,
  parameter int RW    = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_req,
  input  logic [RW-1:0]          in_route,
  output logic                   in_ack,
  output logic [NCH-1:0]         br_req,
  input  logic [NCH-1:0]         br_ack,
  input  logic [NCH-1:0]         rt_req,
  output logic [NCH-1:0]         rt_ack,
  output logic                   out_req,
  output logic [RW-1:0]          out_route,
  input  logic                   out_ack,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   err_route
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_RTZ  = 2'd3;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_FWD  = 2'd1;
  localparam logic [1:0] M_ACK  = 2'd2;
  localparam logic [1:0] M_RTZ  = 2'd3;

  logic [1:0]     split_state_reg;
  logic [RW-1:0]  ch_reg;
  logic           drop_reg;
  logic           in_ack_reg;
  logic [NCH-1:0] br_req_reg;
  logic           err_reg;

  logic [1:0]     merge_state_reg;
  logic [NCH-1:0] rt_ack_reg;
  logic           out_req_reg;
  logic [RW-1:0]  out_route_reg;

  logic [RW-1:0]  fifo_mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;

  logic           route_ok;
  logic           full_int;
  logic           empty_int;
  logic [RW-1:0]  head;
  logic           push;
  logic           pop;

  assign route_ok  = (32'(in_route) < NCH);
  assign full_int  = (count_reg == CW'(DEPTH));
  assign empty_int = (count_reg == '0);
  assign head      = fifo_mem[rd_ptr_reg];
  assign push      = (split_state_reg == S_IDLE) && in_req && route_ok && !full_int;
  // The pop coincides with the final merge phase, so the freed slot is usable next cycle.
  assign pop       = (merge_state_reg == M_RTZ) && !out_ack;

  // Split side: accept, forward to the selected branch, return-to-zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      split_state_reg <= S_IDLE;
      ch_reg          <= '0;
      drop_reg        <= 1'b0;
      in_ack_reg      <= 1'b0;
      br_req_reg      <= '0;
      err_reg         <= 1'b0;
    end else begin
      case (split_state_reg)
        S_IDLE: begin
          if (in_req) begin
            if (!route_ok) begin
              err_reg         <= 1'b1;
              drop_reg        <= 1'b1;
              in_ack_reg      <= 1'b1;
              split_state_reg <= S_ACK;
            end else if (!full_int) begin
              ch_reg          <= in_route;
              drop_reg        <= 1'b0;
              br_req_reg      <= NCH'(1) << in_route;
              split_state_reg <= S_FWD;
            end
          end
        end
        S_FWD: begin
          if (br_ack[ch_reg]) begin
            in_ack_reg      <= 1'b1;
            split_state_reg <= S_ACK;
          end
        end
        S_ACK: begin
          if (!in_req) begin
            br_req_reg      <= '0;
            split_state_reg <= S_RTZ;
          end
        end
        S_RTZ: begin
          if (drop_reg || !br_ack[ch_reg]) begin
            in_ack_reg      <= 1'b0;
            split_state_reg <= S_IDLE;
          end
        end
        default: split_state_reg <= S_IDLE;
      endcase
    end
  end

  // Merge side: only the FIFO head's completion is ever acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      merge_state_reg <= M_IDLE;
      rt_ack_reg      <= '0;
      out_req_reg     <= 1'b0;
      out_route_reg   <= '0;
    end else begin
      case (merge_state_reg)
        M_IDLE: begin
          if (!empty_int && rt_req[head]) begin
            out_req_reg     <= 1'b1;
            out_route_reg   <= head;
            merge_state_reg <= M_FWD;
          end
        end
        M_FWD: begin
          if (out_ack) begin
            rt_ack_reg      <= NCH'(1) << out_route_reg;
            merge_state_reg <= M_ACK;
          end
        end
        M_ACK: begin
          if (!rt_req[out_route_reg]) begin
            out_req_reg     <= 1'b0;
            merge_state_reg <= M_RTZ;
          end
        end
        M_RTZ: begin
          if (!out_ack) begin
            rt_ack_reg      <= '0;
            merge_state_reg <= M_IDLE;
          end
        end
        default: merge_state_reg <= M_IDLE;
      endcase
    end
  end

  // Route storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_route;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign in_ack    = in_ack_reg;
  assign br_req    = br_req_reg;
  assign rt_ack    = rt_ack_reg;
  assign out_req   = out_req_reg;
  assign out_route = out_route_reg;
  assign count     = count_reg;
  assign full      = full_int;
  assign empty     = empty_int;
  assign err_route = err_reg;

endmodule
